cube_root_scheduler: RTL

- Shares one iterative cube-root engine (32-bit radicand, 11-bit root, one root bit per cycle) between NUM_REQ requesters.
- Arbitrates round-robin and holds the engine input stable. Pulses the engine clear, counts iterations, captures the root and returns it with the requester ID over a valid/ready response channel.
- Sits between the client ports and the cube-root calculator instance.

---
 rtl/cube_root_pkg.sv | 25 ++
 rtl/cube_root_rr_arbiter.sv | 32 +++
 rtl/cube_root_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/cube_root_pkg.sv
// Shared constants, FSM state type and helpers for the cube-root engine scheduler.
package cube_root_pkg;

    localparam int unsigned RADICAND_W = 32;
    localparam int unsigned ROOT_W     = 11;
    localparam int unsigned ITERS      = 11;
    localparam int unsigned ITER_W     = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

`ifdef CUBE_ROOT_REM_EN
    // 2047^3 still fits in 33 bits, so the remainder never wraps.
    function automatic logic [RADICAND_W:0] cube33(input logic [ROOT_W-1:0] r);
        logic [RADICAND_W:0] r33;
        r33 = {{(RADICAND_W + 1 - ROOT_W){1'b0}}, r};
        return r33 * r33 * r33;
    endfunction
`endif

endpackage

// File: rtl/cube_root_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, circularly.
module cube_root_rr_arbiter
    import cube_root_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cube_root_scheduler.sv
// Shares one iterative cube-root engine among NUM_REQ requesters with a valid/ready response.
// Define CUBE_ROOT_REM_EN to add the rsp_rem output (radicand minus root cubed).
module cube_root_scheduler
    import cube_root_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned ITERS   = cube_root_pkg::ITERS
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*RADICAND_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [RADICAND_W-1:0]         eng_in,
    output logic                          eng_clear,
    input  logic [ROOT_W-1:0]             eng_root,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
`ifdef CUBE_ROOT_REM_EN
    output logic [RADICAND_W-1:0]         rsp_rem,
`endif
    output logic [ROOT_W-1:0]             rsp_root
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cur_id;
    logic [IDX_W-1:0]   gidx;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W-1:0]   iter_cnt;

    cube_root_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx)
    );

    // Reset dominates, so no grant is offered while clear is high.
    assign req_ready = (state == IDLE && !clear) ? grant : '0;
    assign eng_clear = clear || (state == LOAD);

`ifdef CUBE_ROOT_REM_EN
    logic [RADICAND_W:0] rem_full;
    assign rem_full = {1'b0, eng_in} - cube33(eng_root);
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            iter_cnt  <= '0;
            eng_in    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_root  <= '0;
`ifdef CUBE_ROOT_REM_EN
            rsp_rem   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        eng_in <= req_data[gidx*RADICAND_W +: RADICAND_W];
                        cur_id <= gidx;
                        rr_ptr <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    iter_cnt <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (iter_cnt == CNT_W'(ITERS - 1)) begin
                        iter_cnt  <= '0;
                        rsp_root  <= eng_root;
                        rsp_id    <= ID_W'(cur_id);
                        rsp_valid <= 1'b1;
`ifdef CUBE_ROOT_REM_EN
                        rsp_rem   <= rem_full[RADICAND_W-1:0];
`endif
                        state     <= DONE;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
